// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: decoded fields in from the injector, packed word out to imem.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder (check, then pack) with saturating handshake counters.
// Optional immediate range check enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_if.slave        bus,
    output logic [15:0]           enc_count,
    output logic [15:0]           err_count
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FMT_W  = 3;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;

    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [FMT_W-1:0] FMT_I = 3'd0;
    localparam logic [FMT_W-1:0] FMT_S = 3'd1;
    localparam logic [FMT_W-1:0] FMT_B = 3'd2;
    localparam logic [FMT_W-1:0] FMT_U = 3'd3;
    localparam logic [FMT_W-1:0] FMT_J = 3'd4;
    localparam logic [FMT_W-1:0] FMT_R = 3'd5;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
        logic             bad;
    } s1_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_instr_q, out_instr_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             s1_advance_c;
    logic             in_fire_c;
    logic             out_fire_c;
    logic             range_bad_c;
    logic             bad_c;
    logic [XLEN-1:0]  packed_c;

    // S1 may move forward whenever S2 is empty or draining this cycle.
    assign s1_advance_c = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s1_advance_c;
    assign in_fire_c    = bus.in_valid && bus.in_ready;
    assign out_fire_c   = out_valid_q && bus.out_ready;

    // Immediate range check on the incoming fields.
    always_comb begin
        range_bad_c = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        case (bus.in_fmt)
            FMT_I, FMT_S: range_bad_c = (bus.in_imm[31:11] != '0) && (bus.in_imm[31:11] != '1);
            FMT_B:        range_bad_c = ((bus.in_imm[31:12] != '0) && (bus.in_imm[31:12] != '1))
                                        || bus.in_imm[0];
            FMT_J:        range_bad_c = ((bus.in_imm[31:20] != '0) && (bus.in_imm[31:20] != '1))
                                        || bus.in_imm[0];
            FMT_U:        range_bad_c = (bus.in_imm[11:0] != '0);
            default:      range_bad_c = 1'b0;
        endcase
`endif
        bad_c = (bus.in_fmt > FMT_R) || range_bad_c;
    end

    // S1: capture fields on input handshake, empty when passed on without refill.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_fire_c) begin
            s1_valid_d  = 1'b1;
            s1_d.fmt    = bus.in_fmt;
            s1_d.opcode = bus.in_opcode;
            s1_d.rd     = bus.in_rd;
            s1_d.rs1    = bus.in_rs1;
            s1_d.rs2    = bus.in_rs2;
            s1_d.funct3 = bus.in_funct3;
            s1_d.funct7 = bus.in_funct7;
            s1_d.imm    = bus.in_imm;
            s1_d.bad    = bad_c;
        end else if (s1_advance_c) begin
            s1_valid_d = 1'b0;
        end
    end

    // Immediate scrambling per instruction format.
    always_comb begin
        packed_c = NOP_INSTR;
        case (s1_q.fmt)
            FMT_I: packed_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            FMT_S: packed_c = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                               s1_q.imm[4:0], s1_q.opcode};
            FMT_B: packed_c = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                               s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            FMT_U: packed_c = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            FMT_J: packed_c = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                               s1_q.rd, s1_q.opcode};
            FMT_R: packed_c = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            default: packed_c = NOP_INSTR;
        endcase
        if (s1_q.bad) begin
            packed_c = NOP_INSTR;
        end
    end

    // S2: load from S1 when allowed, otherwise hold stable under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        if (s1_advance_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_instr_d = packed_c;
                out_err_d   = s1_q.bad;
            end
        end
    end

    // Saturating statistics, advanced only by completed output handshakes.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (out_fire_c) begin
            if (enc_count_q != CNT_MAX) begin
                enc_count_d = enc_count_q + CNT_W'(1);
            end
            if (out_err_q && (err_count_q != CNT_MAX)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;
    assign enc_count     = enc_count_q;
    assign err_count     = err_count_q;

endmodule
